// File: rtl/l0_skew_buffer.sv
// l0_skew_buffer: input-side staging buffer for the systolic MAC array.
//
// Holds one FIFO per array row. A write pushes one slice into every row on
// the same edge; a read launches a skewed drain in which row i pops i cycles
// after row 0. The result is the diagonal wavefront that the west-edge
// inputs of the mac_tile rows expect.
//
// Ports:
//   clk      - single clock, all state on the rising edge
//   reset    - asynchronous, active-high
//   in       - row*bw write vector, slice i = in[bw*(i+1)-1 : bw*i]
//   wr       - write request (dropped while o_full)
//   rd       - read request (dropped while o_empty), starts one skewed drain
//   out      - registered read data, same slicing as in
//   o_valid  - bit i high for the cycle slice i holds a freshly popped word
//   o_full   - a write this cycle is not accepted
//   o_empty  - a read this cycle is not accepted

// l0_skew_row: one row FIFO with registered read port.
//
// Ports:
//   clk, reset - as top
//   push       - accepted write for this row
//   pop        - pop this row on this edge
//   din        - slice to write
//   dout       - last popped word (held between pops)
//   pop_vld    - one-cycle strobe marking a fresh word on dout
//   count      - occupancy, 0..depth
module l0_skew_row #(
    parameter int bw      = 4,
    parameter int depth   = 16,
    parameter int addr_bw = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [bw-1:0]     din,
    output logic [bw-1:0]     dout,
    output logic              pop_vld,
    output logic [addr_bw:0]  count
);

    logic [bw-1:0]      mem [depth];
    logic [addr_bw-1:0] wptr;
    logic [addr_bw-1:0] rptr;

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dout    <= '0;
            pop_vld <= 1'b0;
        end else begin
            pop_vld <= pop;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module l0_skew_buffer #(
    parameter int row     = 8,
    parameter int bw      = 4,
    parameter int depth   = 16,
    parameter int addr_bw = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [row*bw-1:0] in,
    input  logic              wr,
    input  logic              rd,
    output logic [row*bw-1:0] out,
    output logic [row-1:0]    o_valid,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [addr_bw:0] full_cnt = (addr_bw+1)'(depth);

    logic [row-1:0][addr_bw:0] cnt;
    logic [row-1:0]            row_empty;
    logic [row-1:0]            row_full;
    logic                      wr_ok;
    logic                      rd_ok;
    logic [row-1:1]            rd_q;
    logic [row-1:0]            rd_sh;

    assign wr_ok = wr & ~o_full;
    assign rd_ok = rd & ~o_empty;

    // rd_sh[0] is the read accepted this cycle; the higher bits are its
    // registered history, so row i sees the same read i cycles later.
    assign rd_sh = {rd_q, rd_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_sh[row-2:0];
        end
    end

    genvar i;
    generate
        for (i = 0; i < row; i++) begin : g_row
            l0_skew_row #(
                .bw      (bw),
                .depth   (depth),
                .addr_bw (addr_bw)
            ) u_row (
                .clk     (clk),
                .reset   (reset),
                .push    (wr_ok),
                .pop     (rd_sh[i]),
                .din     (in[bw*i +: bw]),
                .dout    (out[bw*i +: bw]),
                .pop_vld (o_valid[i]),
                .count   (cnt[i])
            );

            assign row_empty[i] = (cnt[i] == '0);
            assign row_full[i]  = (cnt[i] == full_cnt);
        end
    endgenerate

    // Writes hit all rows together and row i never pops before row i-1, so
    // occupancy is non-decreasing with row index. Row 0 is therefore empty
    // exactly when any row is empty, and the last row is full exactly when
    // any row is full; the OR-reductions equal the row-0 / last-row tests.
    assign o_empty = |row_empty;
    assign o_full  = |row_full;

endmodule

// File: tb/tb_l0_skew_buffer.sv
module tb_l0_skew_buffer;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MAXC  = 8192;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                wr = 1'b0;
    logic                rd = 1'b0;
    logic [ROW*BW-1:0]   in = '0;
    logic [ROW*BW-1:0]   out;
    logic [ROW-1:0]      o_valid;
    logic                o_full;
    logic                o_empty;

    always #5 clk = ~clk;

    l0_skew_buffer #(.row(ROW), .bw(BW), .depth(DEPTH), .addr_bw(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    // Reference model: per-row queues as circular arrays with unbounded
    // head/tail counters, plus a record of which cycles accepted a read.
    int                 tot = 0;
    int                 bad = 0;
    logic [BW-1:0]      mdat [ROW][256];
    int                 mh [ROW];
    int                 mt [ROW];
    bit                 acc [MAXC];
    int                 cyc = 0;
    logic [ROW*BW-1:0]  eout = '0;
    logic [ROW-1:0]     ev = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mcnt(input int r);
        return mt[r] - mh[r];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROW; r++) begin
            mh[r] = 0;
            mt[r] = 0;
        end
        for (int c = 0; c < MAXC; c++) acc[c] = 1'b0;
        eout = '0;
        ev   = '0;
    endtask

    // One clock cycle: drive, check flags, clock, update model, check data.
    task automatic step(input bit w, input bit r, input logic [ROW*BW-1:0] d);
        bit xe, xf, wa, ra;
        wr = w;
        rd = r;
        in = d;
        #1;
        xe = (mcnt(0) == 0);
        xf = (mcnt(ROW-1) == DEPTH);
        chk("o_empty", {63'd0, o_empty}, {63'd0, xe});
        chk("o_full",  {63'd0, o_full},  {63'd0, xf});
        wa = w && !xf;
        ra = r && !xe;
        @(posedge clk);
        acc[cyc] = ra;
        for (int k = 0; k < ROW; k++) begin
            if (cyc >= k && acc[cyc-k]) begin
                eout[k*BW +: BW] = mdat[k][mh[k] % 256];
                mh[k]++;
                ev[k] = 1'b1;
            end else begin
                ev[k] = 1'b0;
            end
        end
        if (wa) begin
            for (int k = 0; k < ROW; k++) begin
                mdat[k][mt[k] % 256] = d[k*BW +: BW];
                mt[k]++;
            end
        end
        cyc++;
        #1;
        chk("out",     {32'd0, out},     {32'd0, eout});
        chk("o_valid", {56'd0, o_valid}, {56'd0, ev});
    endtask

    // Reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out",   {32'd0, out},     64'd0);
        chk("rst_valid", {56'd0, o_valid}, 64'd0);
        chk("rst_empty", {63'd0, o_empty}, 64'd1);
        chk("rst_full",  {63'd0, o_full},  64'd0);
        wr = 1'b0;
        rd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] kv;
        logic [ROW*BW-1:0] seq;
        model_clear();

        // Reset values
        do_reset();

        // Single skewed read: slice i holds value i
        seq = 32'h7654_3210;
        step(1'b1, 1'b0, seq);
        step(1'b0, 1'b1, '0);
        repeat (ROW + 1) step(1'b0, 1'b0, '0);
        chk("empty_after_pop", {63'd0, o_empty}, 64'd1);

        // Fill, overflow, stream drain; second pass exercises pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < DEPTH; k++) begin
                kv = k[BW-1:0];
                step(1'b1, 1'b0, {ROW{kv}});
            end
            chk("full_after_fill", {63'd0, o_full}, 64'd1);
            step(1'b1, 1'b0, '1);
            for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, '0);
            repeat (ROW) step(1'b0, 1'b0, '0);
            chk("empty_after_drain", {63'd0, o_empty}, 64'd1);
        end

        // Empty read is dropped, then a normal write/read
        step(1'b0, 1'b1, '0);
        repeat (ROW + 1) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, $urandom);
        step(1'b0, 1'b1, '0);
        repeat (ROW) step(1'b0, 1'b0, '0);

        // Concurrent traffic from two entries
        step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        repeat (40) step(1'b1, 1'b1, $urandom);
        chk("concurrent_not_full", {63'd0, o_full}, 64'd0);
        repeat (4) step(1'b0, 1'b1, '0);
        repeat (ROW) step(1'b0, 1'b0, '0);

        // Random traffic with varying write bias to visit full and empty
        for (int ph = 0; ph < 4; ph++) begin
            repeat (80) begin
                step(($urandom_range(0, 3) < (ph % 2 == 0 ? 3 : 1)),
                     ($urandom_range(0, 3) < (ph % 2 == 0 ? 1 : 3)),
                     $urandom);
            end
        end
        repeat (DEPTH + ROW) step(1'b0, 1'b1, '0);
        repeat (ROW) step(1'b0, 1'b0, '0);

        // Reset during skew: rows 0..2 pop, rows 3..7 must never pulse
        step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        do_reset();
        for (int k = 0; k < ROW; k++) begin
            step(1'b0, 1'b0, '0);
            chk("skew_rst_hi_rows", {56'd0, o_valid & 8'hF8}, 64'd0);
        end
        step(1'b0, 1'b1, '0);
        chk("empty_after_skew_rst", {63'd0, o_empty}, 64'd1);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
